seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (supported 8..64, power of two).
REQ-002 SHALL have derived localparam SHAMT_W = $clog2(WIDTH), default 5, shift-amount width.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  reset; synchronous and active-high.
REQ-005 SHALL have in_valid  input  1  operation request valid.
REQ-006 SHALL have in_ready  output  1  block can accept a request.
REQ-007 SHALL have alu_op  input  2  00 load/store ADD, 01 branch SUB, 10 R/I-type decode by funct3, 11 MUL.
REQ-008 SHALL have funct3  input  3  RISC-V funct3 field.
REQ-009 SHALL have funct7_5  input  1  selects SUB (funct3=000) or SRA (funct3=101) when alu_op=10.
REQ-010 SHALL have op_a, op_b  input  WIDTH each  operands.
REQ-011 SHALL have out_valid  output  1  result available.
REQ-012 SHALL have out_ready  input  1  consumer takes result.
REQ-013 SHALL have result  output  WIDTH  operation result.
REQ-014 SHALL have zero  output  1  high when result==0; meaningful only while out_valid=1.
REQ-015 SHALL have illegal  output  1  unsupported operation flag, valid with out_valid.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, MUL, DONE; in_ready=1 only in IDLE.
REQ-017 SHALL accept a request when in_valid&&in_ready, latching alu_op, funct3, funct7_5, op_a, op_b.
REQ-018 SHALL decode alu_op=10: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
REQ-019 SHALL complete ADD, SUB, SLT, SLTU, XOR, OR, AND as IDLE->DONE: out_valid exactly 1 cycle after accept.
REQ-020 SHALL use modulo-2^WIDTH arithmetic for ADD/SUB; SLT signed, SLTU unsigned, result 0 or 1.
REQ-021 SHALL perform shifts iteratively, one bit per cycle in SHIFT, shamt = op_b[SHAMT_W-1:0]; out_valid exactly shamt+1 cycles after accept.
REQ-022 SHALL go IDLE->DONE directly for shamt=0, result=op_a, latency 1.
REQ-023 SHALL sign-fill on SRA, zero-fill on SLL/SRL.
REQ-024 SHALL in DONE hold out_valid=1 and result, zero, illegal stable until out_ready=1, then return to IDLE the next cycle.
REQ-025 SHALL ignore in_valid in SHIFT, MUL and DONE (no request overlap; next accept earliest cycle after DONE exits).
REQ-026 SHALL keep result, zero, illegal at 0 whenever out_valid=0.

Reset
REQ-027 SHALL on reset=1 at any clock edge, including mid-SHIFT/MUL or in DONE, abort the operation and enter IDLE.
REQ-028 SHALL have reset values: in_ready=1 after the reset cycle, out_valid=0, result=0, zero=0, illegal=0, iteration counter=0.
REQ-029 SHALL give reset priority over in_valid and out_ready in the same cycle.

Configuration
REQ-030 SHALL use macro SEQ_ALU_MUL_EN to compile in an iterative shift-add multiplier.
REQ-031 SHALL with SEQ_ALU_MUL_EN defined, execute alu_op=11 (funct3 ignored) as MUL, low WIDTH bits of op_a*op_b, one bit per cycle in MUL, out_valid exactly WIDTH+1 cycles after accept, illegal=0.
REQ-032 SHALL without SEQ_ALU_MUL_EN, treat alu_op=11 as IDLE->DONE with result=0, zero=1, illegal=1, latency 1, and contain no multiplier logic.

Verification (WIDTH=32)
REQ-033 SHALL cover ADD: alu_op=10 funct3=000 funct7_5=0 a=5 b=7 -> out_valid 1 cycle after accept, result=12, zero=0.
REQ-034 SHALL cover SUB: alu_op=01 a=9 b=9 -> result=0, zero=1, illegal=0, latency 1.
REQ-035 SHALL cover SRA: alu_op=10 funct3=101 funct7_5=1 a=0x80000000 b=4 -> out_valid exactly 5 cycles after accept, result=0xF8000000.
REQ-036 SHALL cover backpressure: ADD a=1 b=1 with out_ready=0 for 3 cycles, in_valid=1 held -> out_valid, result=2 stable, in_ready=0, no second accept until cycle after out_ready=1.
REQ-037 SHALL cover reset mid-op: SLL a=1 b=31, reset pulsed 10 cycles after accept -> next cycle out_valid=0, result=0, in_ready=1; no stale result appears.
REQ-038 SHALL cover MUL: alu_op=11 a=6 b=7 -> with SEQ_ALU_MUL_EN result=42 after exactly 33 cycles; without it result=0, illegal=1 after 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential RV32-style ALU: single-cycle logic ops, bit-serial shifts.
// Define SEQ_ALU_MUL_EN to build in the iterative shift-add multiplier.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] MUL_CNT = (SHAMT_W+1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE, SHIFT, MUL, DONE
  } state_e;

  typedef enum logic [1:0] {
    SK_SLL, SK_SRL, SK_SRA
  } shk_e;

  state_e           state_q, state_d;
  shk_e             sk_q, sk_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ill_q, ill_d;
  logic [SHAMT_W:0] cnt_q, cnt_d;
  logic [SHAMT_W-1:0] shamt;
  logic             slt, sltu;
  logic             fill;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
`endif

  assign shamt = op_b[SHAMT_W-1:0];
  assign slt   = $signed(op_a) < $signed(op_b);
  assign sltu  = op_a < op_b;
  assign fill  = (sk_q == SK_SRA) & res_q[WIDTH-1];

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = out_valid ? res_q : '0;
  assign zero      = out_valid & (res_q == '0);
  assign illegal   = out_valid & ill_q;

  always_comb begin
    state_d = state_q;
    sk_d    = sk_q;
    res_d   = res_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
`ifdef SEQ_ALU_MUL_EN
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          ill_d   = 1'b0;
          case (alu_op)
            2'b00: res_d = op_a + op_b;
            2'b01: res_d = op_a - op_b;
            2'b10: begin
              unique case (funct3)
                3'b000: res_d = funct7_5 ? op_a - op_b : op_a + op_b;
                3'b010: res_d = {{(WIDTH-1){1'b0}}, slt};
                3'b011: res_d = {{(WIDTH-1){1'b0}}, sltu};
                3'b100: res_d = op_a ^ op_b;
                3'b110: res_d = op_a | op_b;
                3'b111: res_d = op_a & op_b;
                default: begin
                  // 001/101: shifts run bit-serially on res_q
                  res_d = op_a;
                  if (funct3 == 3'b001) sk_d = SK_SLL;
                  else if (funct7_5)    sk_d = SK_SRA;
                  else                  sk_d = SK_SRL;
                  if (shamt != '0) begin
                    state_d = SHIFT;
                    cnt_d   = {1'b0, shamt};
                  end
                end
              endcase
            end
            default: begin
`ifdef SEQ_ALU_MUL_EN
              state_d = MUL;
              res_d   = '0;
              mcand_d = op_a;
              mplr_d  = op_b;
              cnt_d   = MUL_CNT;
`else
              res_d = '0;
              ill_d = 1'b1;
`endif
            end
          endcase
        end
      end
      SHIFT: begin
        if (sk_q == SK_SLL) res_d = {res_q[WIDTH-2:0], 1'b0};
        else                res_d = {fill, res_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) state_d = DONE;
      end
      MUL: begin
`ifdef SEQ_ALU_MUL_EN
        if (mplr_q[0]) res_d = res_q + mcand_q;
        mcand_d = {mcand_q[WIDTH-2:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == 1) state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          res_d   = '0;
          ill_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sk_q    <= SK_SLL;
      res_q   <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sk_q    <= sk_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q <= '0;
      mplr_q  <= '0;
    end else begin
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu (WIDTH=32).
// MUL expectations follow SEQ_ALU_MUL_EN as defined for the build.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        il;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic addv(input string nm, input logic [1:0] op,
                      input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic z,
                      input logic il, input int lat);
    vec_t v;
    v.nm = nm; v.op = op; v.f3 = f3; v.f7 = f7;
    v.a = a; v.b = b; v.r = r; v.z = z; v.il = il; v.lat = lat;
    vq.push_back(v);
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a,
                       input logic [31:0] b);
    alu_op = op; funct3 = f3; funct7_5 = f7;
    op_a = a; op_b = b; in_valid = 1'b1;
  endtask

  task automatic run_op(input vec_t v, output logic [31:0] r,
                        output logic z, output logic il,
                        output int lat);
    @(negedge clk);
    out_ready = 1'b0;
    drive(v.op, v.f3, v.f7, v.a, v.b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; z = zero; il = illegal;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        z, il;
    int          lat;
    bit          stale;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; funct3 = '0; funct7_5 = 1'b0;
    op_a = '0; op_b = '0;

    addv("add_r",  2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1);
    addv("sub_br", 2'b01, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1);
    addv("add_ls", 2'b00, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    addv("sub_r",  2'b10, 3'b000, 1'b1, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 1);
    addv("slt",    2'b10, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    addv("sltu",   2'b10, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    addv("xor",    2'b10, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1);
    addv("or",     2'b10, 3'b110, 1'b0, 32'hF0F0F0F0, 32'h0F000000, 32'hFFF0F0F0, 1'b0, 1'b0, 1);
    addv("and",    2'b10, 3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1);
    addv("sra4",   2'b10, 3'b101, 1'b1, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 5);
    addv("srl31",  2'b10, 3'b101, 1'b0, 32'h80000000, 32'd31, 32'd1, 1'b0, 1'b0, 32);
    addv("sll3",   2'b10, 3'b001, 1'b0, 32'd1, 32'd3, 32'd8, 1'b0, 1'b0, 4);
    addv("sll0",   2'b10, 3'b001, 1'b0, 32'h1234, 32'h20, 32'h1234, 1'b0, 1'b0, 1);
    addv("sra_pos",2'b10, 3'b101, 1'b1, 32'h40000000, 32'h21, 32'h20000000, 1'b0, 1'b0, 2);
`ifdef SEQ_ALU_MUL_EN
    addv("mul",    2'b11, 3'b000, 1'b0, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 33);
    addv("mul_big",2'b11, 3'b101, 1'b0, 32'h10001, 32'h10001, 32'h00020001, 1'b0, 1'b0, 33);
`else
    addv("mul",    2'b11, 3'b000, 1'b0, 32'd6, 32'd7, 32'd0, 1'b1, 1'b1, 1);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result",    result,    32'd0);
    chk("rst_zero",      zero,      1'b0);
    chk("rst_illegal",   illegal,   1'b0);

    foreach (vq[i]) begin
      run_op(vq[i], r, z, il, lat);
      chk({vq[i].nm, "_res"}, r,   vq[i].r);
      chk({vq[i].nm, "_zero"}, z,  vq[i].z);
      chk({vq[i].nm, "_ill"}, il,  vq[i].il);
      chk({vq[i].nm, "_lat"}, lat, vq[i].lat);
      chk({vq[i].nm, "_idle_res"}, {out_valid, result}, 33'd0);
    end

    // Backpressure with in_valid held high throughout
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 32'd1, 32'd1);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, 32'd2);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_second_res", result, 32'd2);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);

    // Reset ten cycles into a 31-bit shift
    out_ready = 1'b1;
    drive(2'b10, 3'b001, 1'b0, 32'd1, 32'd31);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", in_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_ready", in_ready, 1'b1);
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    chk("mid_no_stale", stale, 1'b0);

    // Reset while holding a result, with in_valid and out_ready also high
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 32'd3, 32'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_hold", result, 32'd7);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk("done_rst_valid", out_valid, 1'b0);
    chk("done_rst_result", result, 32'd0);
    chk("done_rst_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
